// File: rtl/alarm_multi_timer_if.sv
// Avalon-MM slave window of the multi-channel timer, plus its per-channel interrupt lines.
// The address is {channel, reg[1:0]} in word units.
interface alarm_multi_timer_if #(
  parameter int NUM_CH = 4
);
  localparam int AW = $clog2(NUM_CH) + 2;

  logic              chipselect;
  logic [AW-1:0]     address;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;

  modport slave (
    input  chipselect, address, write_n, writedata,
    output readdata, irq, irq_any
  );

  modport master (
    output chipselect, address, write_n, writedata,
    input  readdata, irq, irq_any
  );
endinterface

// File: rtl/alarm_multi_timer.sv
// NUM_CH independent prescaled down-counters behind one register window.
// Each channel supports one-shot/continuous mode, a snapshot register and a level IRQ.
module alarm_timer_ch #(
  parameter int          CNT_W          = 32,
  parameter int          PRESC_W        = 16,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h0098967F
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wr_status_i,
  input  logic        wr_ctrl_i,
  input  logic        wr_period_i,
  input  logic        wr_snap_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  reg_sel_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);
  // A zero-width prescaler is carried as a constant-zero single bit.
  localparam int             PW  = (PRESC_W > 0) ? PRESC_W : 1;
  localparam logic [CNT_W-1:0] DEF = DEFAULT_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0] count_q, count_d, period_q, period_d, snap_q, snap_d;
  logic [PW-1:0]    pcnt_q, pcnt_d, presc_q, presc_d, presc_wr;
  logic             ito_q, ito_d, cont_q, cont_d, run_q, run_d, to_q, to_d;
  logic             tick, timeout;

  always_comb begin
    tick     = run_q && (pcnt_q == '0);
    timeout  = tick && (count_q == '0);
    presc_wr = (PRESC_W > 0) ? wdata_i[16 +: PW] : '0;
    count_d  = count_q;
    period_d = period_q;
    snap_d   = snap_q;
    pcnt_d   = pcnt_q;
    presc_d  = presc_q;
    ito_d    = ito_q;
    cont_d   = cont_q;
    run_d    = run_q;
    to_d     = to_q;

    // The tick always reloads from the PRESC held before any same-cycle write.
    if (run_q) pcnt_d = tick ? presc_q : pcnt_q - 1'b1;
    if (tick)  count_d = (count_q == '0) ? period_q : count_q - 1'b1;
    if (timeout) begin
      to_d  = 1'b1;
      run_d = cont_q;
    end
    if (wr_status_i) to_d = 1'b0;
    if (wr_ctrl_i) begin
      ito_d   = wdata_i[0];
      cont_d  = wdata_i[1];
      presc_d = presc_wr;
      if (wdata_i[2])      run_d = 1'b1;
      else if (wdata_i[3]) run_d = 1'b0;
    end
    if (wr_period_i) begin
      period_d = wdata_i[CNT_W-1:0];
      count_d  = wdata_i[CNT_W-1:0];
      pcnt_d   = presc_q;
      run_d    = 1'b0;
    end
    if (wr_snap_i) snap_d = count_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q  <= DEF;
      period_q <= DEF;
      snap_q   <= '0;
      pcnt_q   <= '0;
      presc_q  <= '0;
      ito_q    <= 1'b0;
      cont_q   <= 1'b0;
      run_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
      snap_q   <= snap_d;
      pcnt_q   <= pcnt_d;
      presc_q  <= presc_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
      run_q    <= run_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    unique case (reg_sel_i)
      2'd0: rdata_o = {30'b0, run_q, to_q};
      2'd1: begin
        rdata_o[0] = ito_q;
        rdata_o[1] = cont_q;
        if (PRESC_W > 0) rdata_o[16 +: PW] = presc_q;
      end
      2'd2: rdata_o = 32'(period_q);
      2'd3: rdata_o = 32'(snap_q);
      default: rdata_o = '0;
    endcase
  end

  assign irq_o = to_q & ito_q;
endmodule

module alarm_multi_timer #(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 32,
  parameter int          PRESC_W        = 16,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h0098967F
) (
  input  logic              clk_i,
  input  logic              reset_i,
  alarm_multi_timer_if.slave bus
);
  localparam int AW = $clog2(NUM_CH) + 2;

  logic                         wr;
  logic [AW-1:0]                ch_sel;
  logic [1:0]                   reg_sel;
  logic [NUM_CH-1:0]            hit, ch_irq;
  logic [NUM_CH-1:0][31:0]      ch_rdata;
  logic [31:0]                  readdata_q, readdata_d;

  assign wr      = bus.chipselect & ~bus.write_n;
  assign ch_sel  = bus.address >> 2;
  assign reg_sel = bus.address[1:0];

  // Channel codes >= NUM_CH match no channel: writes drop, reads return 0.
  always_comb begin
    hit        = '0;
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = (ch_sel == AW'(i));
      if (hit[i]) readdata_d = ch_rdata[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    alarm_timer_ch #(
      .CNT_W         (CNT_W),
      .PRESC_W       (PRESC_W),
      .DEFAULT_PERIOD(DEFAULT_PERIOD)
    ) u_ch (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .wr_status_i(wr && hit[g] && (reg_sel == 2'd0)),
      .wr_ctrl_i  (wr && hit[g] && (reg_sel == 2'd1)),
      .wr_period_i(wr && hit[g] && (reg_sel == 2'd2)),
      .wr_snap_i  (wr && hit[g] && (reg_sel == 2'd3)),
      .wdata_i    (bus.writedata),
      .reg_sel_i  (reg_sel),
      .rdata_o    (ch_rdata[g]),
      .irq_o      (ch_irq[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) readdata_q <= '0;
    else         readdata_q <= readdata_d;
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = ch_irq;
  assign bus.irq_any  = |ch_irq;
endmodule

// File: tb/tb_alarm_multi_timer.sv
// Directed bench for alarm_multi_timer: register access, timeout timing, event priorities and reset.
module tb_alarm_multi_timer;
  localparam logic [31:0] DEF = 32'h0098967F;

  logic clk_i = 1'b0;
  logic reset_i;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] d;
  int   n;

  alarm_multi_timer_if #(.NUM_CH(4)) bus ();

  alarm_multi_timer #(
    .NUM_CH(4), .CNT_W(32), .PRESC_W(16), .DEFAULT_PERIOD(DEF)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = v;
    @(posedge clk_i); #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    bus.address = a;
    @(posedge clk_i); #1;
    v = bus.readdata;
  endtask

  task automatic tick_n(input int k);
    repeat (k) @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i        = 1'b1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;
    tick_n(2);
    reset_i = 1'b0;

    // 1: reset state and read latency
    chk("rst_readdata", bus.readdata, 32'h0);
    chk("rst_irq", {28'b0, bus.irq}, 32'h0);
    rd(4'd2, d);  chk("rst_ch0_period", d, DEF);
    rd(4'd4, d);  chk("rst_ch1_status", d, 32'h0);

    // 2: ch0 one-shot, PERIOD=4 -> timeout 5 clks after RUN
    wr(4'd2, 32'd4);
    wr(4'd1, 32'h5);
    for (int k = 1; k <= 4; k++) begin
      chk("t2_no_irq_early", {31'b0, bus.irq[0]}, 32'h0);
      tick_n(1);
    end
    tick_n(1);
    chk("t2_irq0", {31'b0, bus.irq[0]}, 32'h1);
    chk("t2_irq_any", {31'b0, bus.irq_any}, 32'h1);
    rd(4'd0, d);  chk("t2_status_to_norun", d, 32'h1);
    wr(4'd0, 32'h0);
    chk("t2_irq0_cleared", {31'b0, bus.irq[0]}, 32'h0);

    // 3: ch1 continuous, PERIOD=2 PRESC=3 -> every 12 clks
    wr(4'd5, 32'h0003_0003);
    wr(4'd6, 32'd2);
    wr(4'd5, 32'h0003_0007);
    n = 0;
    do begin tick_n(1); n++; end while (!bus.irq[1] && n < 40);
    chk("t3_first_period", 32'(n), 32'd12);
    for (int p = 0; p < 3; p++) begin
      wr(4'd4, 32'h0);
      n = 1;
      do begin tick_n(1); n++; end while (!bus.irq[1] && n < 40);
      chk("t3_period", 32'(n), 32'd12);
    end
    rd(4'd4, d);  chk("t3_status_run", d, 32'h3);
    wr(4'd5, 32'h0003_000B);
    wr(4'd4, 32'h0);
    chk("t3_quiet", {28'b0, bus.irq}, 32'h0);

    // 4: ch2 STATUS clear lands on the timeout clk
    wr(4'd10, 32'd3);
    wr(4'd9, 32'h7);
    tick_n(3);
    wr(4'd8, 32'h0);
    chk("t4_clear_wins", {31'b0, bus.irq[2]}, 32'h0);
    rd(4'd8, d);  chk("t4_status", d, 32'h2);
    tick_n(2);
    chk("t4_before_next", {31'b0, bus.irq[2]}, 32'h0);
    tick_n(1);
    chk("t4_next_timeout", {31'b0, bus.irq[2]}, 32'h1);
    wr(4'd9, 32'hB);
    wr(4'd8, 32'h0);

    // 5: ch3 snapshot and forced reload by PERIOD write
    wr(4'd14, 32'd50);
    wr(4'd13, 32'h4);
    tick_n(2);
    wr(4'd15, 32'h0);
    rd(4'd15, d);  chk("t5_snap_predec", d, 32'd48);
    wr(4'd14, 32'd100);
    rd(4'd12, d);  chk("t5_stopped", d, 32'h0);
    wr(4'd15, 32'h0);
    rd(4'd15, d);  chk("t5_reloaded", d, 32'd100);
    wr(4'd13, 32'h4);
    wr(4'd15, 32'h0);
    rd(4'd15, d);  chk("t5_resume_from", d, 32'd100);
    wr(4'd15, 32'h0);
    rd(4'd15, d);  chk("t5_counting", d, 32'd98);

    // 6: START|STOP -> START wins; then reset mid-count
    wr(4'd1, 32'hC);
    rd(4'd0, d);  chk("t6_start_wins", d, 32'h2);
    rd(4'd1, d);  chk("t6_ctrl_strobes_zero", d, 32'h0);
    reset_i = 1'b1;
    tick_n(1);
    chk("t6_rst_readdata", bus.readdata, 32'h0);
    chk("t6_rst_irq", {28'b0, bus.irq}, 32'h0);
    tick_n(1);
    reset_i = 1'b0;
    tick_n(6);
    chk("t6_no_irq_after", {31'b0, bus.irq_any}, 32'h0);
    rd(4'd0, d);   chk("t6_ch0_status", d, 32'h0);
    rd(4'd1, d);   chk("t6_ch0_ctrl", d, 32'h0);
    rd(4'd14, d);  chk("t6_ch3_period", d, DEF);
    rd(4'd15, d);  chk("t6_ch3_snap", d, 32'h0);
    wr(4'd3, 32'h0);
    rd(4'd3, d);   chk("t6_ch0_count", d, DEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
